// File: rtl/snake_frame_engine.sv
// rtl/snake_frame_engine.sv - video timing, grid snake game state and two-stage pixel renderer
//
// Purpose: generates raster timing, runs a multi-segment snake on a cell grid
// (circular body buffer, grow/shrink, wall/self collision, lives) and renders
// it. All game state changes on the frame tick, which falls in vertical blanking.
//
// Ports:
//   clk                      pixel clock
//   reset_n                  asynchronous active-low reset
//   dir[1:0]                 heading request: 01 right, 10 left, 11 up, 00 down
//   grow_evt/shrink_evt/life_evt  single-cycle event pulses, latched until next step
//   hsync/vsync/de           timing outputs, 2-cycle latency from the counters
//   pixel[23:0]              RGB888, aligned with de, zero outside active video
//   frame_tick               one-cycle pulse at start of vertical blanking
//   head_x/head_y            current head cell
//   lives[2:0]               remaining lives
//   game_over                sticky, cleared only by reset
module snake_frame_engine #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int CELL_LOG2  = 3,
    parameter int MAX_LEN    = 16,
    parameter int INIT_LEN   = 3,
    parameter int MOVE_DIV   = 4,
    parameter int LIVES_INIT = 3,
    parameter int LIVES_MAX  = 3
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [1:0]                               dir,
    input  logic                                     grow_evt,
    input  logic                                     shrink_evt,
    input  logic                                     life_evt,
    output logic                                     hsync,
    output logic                                     vsync,
    output logic                                     de,
    output logic [23:0]                              pixel,
    output logic                                     frame_tick,
    output logic [$clog2(H_ACTIVE >> CELL_LOG2)-1:0] head_x,
    output logic [$clog2(V_ACTIVE >> CELL_LOG2)-1:0] head_y,
    output logic [2:0]                               lives,
    output logic                                     game_over
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int GRID_W  = H_ACTIVE >> CELL_LOG2;
    localparam int GRID_H  = V_ACTIVE >> CELL_LOG2;
    localparam int XW      = $clog2(GRID_W);
    localparam int YW      = $clog2(GRID_H);
    localparam int XW1     = XW + 1;
    localparam int YW1     = YW + 1;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = $clog2(MAX_LEN);
    localparam int LW      = PW + 1;
    localparam int FW      = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]  HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]  HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]  VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]  VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [XW1-1:0] GW_LIM   = XW1'(GRID_W);
    localparam logic [YW1-1:0] GH_LIM   = YW1'(GRID_H);
    localparam logic [XW-1:0]  X_MID    = XW'(GRID_W / 2);
    localparam logic [YW-1:0]  Y_MID    = YW'(GRID_H / 2);
    localparam logic [LW-1:0]  LEN_MAX  = LW'(MAX_LEN);
    localparam logic [LW-1:0]  LEN_INIT = LW'(INIT_LEN);
    localparam logic [LW-1:0]  LEN_ONE  = LW'(1);
    localparam logic [PW-1:0]  HP_INIT  = PW'(INIT_LEN - 1);
    localparam logic [FW-1:0]  FC_LAST  = FW'(MOVE_DIV - 1);
    localparam logic [2:0]     LIVES_RST = 3'(LIVES_INIT);
    localparam logic [2:0]     LIVES_TOP = 3'(LIVES_MAX);

    localparam logic [1:0] DIR_DOWN  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    always_comb begin
        h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // ------------------------------------------------------------------
    // Game state
    // ------------------------------------------------------------------
    logic [XW-1:0] bx_q [MAX_LEN];
    logic [YW-1:0] by_q [MAX_LEN];
    logic [XW-1:0] hx_q, hx_d;
    logic [YW-1:0] hy_q, hy_d;
    logic [PW-1:0] hp_q, hp_d;
    logic [LW-1:0] len_q, len_d;
    logic [1:0]    hd_q, hd_d;
    logic [FW-1:0] fc_q, fc_d;
    logic [2:0]    lives_q, lives_d;
    logic          go_q, go_d;
    logic          pg_q, pg_d, ps_q, ps_d, pl_q, pl_d;
    logic          tick_q;
    logic          tick, step, dead, hit, advance, respawn;
    logic [1:0]    hd_next;
    logic [XW1-1:0] next_x;
    logic [YW1-1:0] next_y;

    assign tick = (h_q == '0) && (v_q == V_ACT);
    assign step = tick && (fc_q == FC_LAST) && !go_q;

    // A request exactly opposite the current heading is its bitwise inverse.
    assign hd_next = (dir == ~hd_q) ? hd_q : dir;

    // One extra bit so that stepping off either edge lands outside the grid
    // (0 - 1 wraps to all-ones, which is always >= the grid size).
    always_comb begin
        next_x = {1'b0, hx_q};
        next_y = {1'b0, hy_q};
        case (hd_next)
            DIR_RIGHT: next_x = {1'b0, hx_q} + 1'b1;
            DIR_LEFT:  next_x = {1'b0, hx_q} - 1'b1;
            DIR_UP:    next_y = {1'b0, hy_q} - 1'b1;
            default:   next_y = {1'b0, hy_q} + 1'b1;
        endcase
    end

    // Segments 1..len-2 only: the tail moves out of its cell on this step.
    always_comb begin
        hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LW'(i + 1) < len_q) &&
                (bx_q[PW'(hp_q - PW'(i))] == next_x[XW-1:0]) &&
                (by_q[PW'(hp_q - PW'(i))] == next_y[YW-1:0])) begin
                hit = 1'b1;
            end
        end
    end

    assign dead = (next_x >= GW_LIM) || (next_y >= GH_LIM) || hit;

    always_comb begin
        hx_d     = hx_q;
        hy_d     = hy_q;
        hp_d     = hp_q;
        len_d    = len_q;
        hd_d     = hd_q;
        lives_d  = lives_q;
        go_d     = go_q;
        pg_d     = pg_q;
        ps_d     = ps_q;
        pl_d     = pl_q;
        advance  = 1'b0;
        respawn  = 1'b0;
        fc_d     = fc_q;
        if (tick) begin
            fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
        end
        if (!go_q) begin
            pg_d = pg_q | grow_evt;
            ps_d = ps_q | shrink_evt;
            pl_d = pl_q | life_evt;
        end
        if (step) begin
            // Events in the step cycle itself belong to the next step.
            hd_d = hd_next;
            pg_d = grow_evt;
            ps_d = shrink_evt;
            pl_d = life_evt;
            if (dead) begin
                lives_d = lives_q - 3'd1;
                if (lives_q == 3'd1) begin
                    go_d = 1'b1;
                end else begin
                    respawn = 1'b1;
                    hx_d    = X_MID;
                    hy_d    = Y_MID;
                    hp_d    = HP_INIT;
                    len_d   = LEN_INIT;
                    hd_d    = DIR_RIGHT;
                end
            end else begin
                advance = 1'b1;
                hp_d    = hp_q + 1'b1;
                hx_d    = next_x[XW-1:0];
                hy_d    = next_y[YW-1:0];
                if (pg_q && !ps_q && (len_q != LEN_MAX)) begin
                    len_d = len_q + 1'b1;
                end else if (ps_q && !pg_q && (len_q != LEN_ONE)) begin
                    len_d = len_q - 1'b1;
                end
                if (pl_q && (lives_q != LIVES_TOP)) begin
                    lives_d = lives_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < MAX_LEN; j++) begin
                bx_q[j] <= XW'(GRID_W / 2 - INIT_LEN + 1 + j);
                by_q[j] <= Y_MID;
            end
            hx_q    <= X_MID;
            hy_q    <= Y_MID;
            hp_q    <= HP_INIT;
            len_q   <= LEN_INIT;
            hd_q    <= DIR_RIGHT;
            fc_q    <= '0;
            lives_q <= LIVES_RST;
            go_q    <= 1'b0;
            pg_q    <= 1'b0;
            ps_q    <= 1'b0;
            pl_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            if (respawn) begin
                for (int j = 0; j < MAX_LEN; j++) begin
                    bx_q[j] <= XW'(GRID_W / 2 - INIT_LEN + 1 + j);
                    by_q[j] <= Y_MID;
                end
            end else if (advance) begin
                bx_q[hp_d] <= hx_d;
                by_q[hp_d] <= hy_d;
            end
            hx_q    <= hx_d;
            hy_q    <= hy_d;
            hp_q    <= hp_d;
            len_q   <= len_d;
            hd_q    <= hd_d;
            fc_q    <= fc_d;
            lives_q <= lives_d;
            go_q    <= go_d;
            pg_q    <= pg_d;
            ps_q    <= ps_d;
            pl_q    <= pl_d;
            tick_q  <= tick;
        end
    end

    // ------------------------------------------------------------------
    // Renderer: stage 1 decodes counters, stage 2 compares and colours
    // ------------------------------------------------------------------
    logic          s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic [XW-1:0] s1_cx_q, s1_cx_d;
    logic [YW-1:0] s1_cy_q, s1_cy_d;
    logic          hs_q, vs_q, de_q;
    logic [23:0]   pix_q, pix_d;
    logic          head_hit, body_hit;

    always_comb begin
        s1_de_d = (h_q < H_ACT) && (v_q < V_ACT);
        s1_hs_d = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        s1_vs_d = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        s1_cx_d = XW'(h_q >> CELL_LOG2);
        s1_cy_d = YW'(v_q >> CELL_LOG2);
    end

    always_comb begin
        head_hit = (s1_cx_q == hx_q) && (s1_cy_q == hy_q);
        body_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < len_q) &&
                (bx_q[PW'(hp_q - PW'(i))] == s1_cx_q) &&
                (by_q[PW'(hp_q - PW'(i))] == s1_cy_q)) begin
                body_hit = 1'b1;
            end
        end
        if (!s1_de_q) begin
            pix_d = 24'h000000;
        end else if (head_hit) begin
            pix_d = 24'hFFFF00;
        end else if (body_hit) begin
            pix_d = 24'h00FF00;
        end else if (go_q) begin
            pix_d = 24'h400000;
        end else begin
            pix_d = 24'h000000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_de_q <= 1'b0;
            s1_hs_q <= ~HSYNC_POL;
            s1_vs_q <= ~VSYNC_POL;
            s1_cx_q <= '0;
            s1_cy_q <= '0;
            hs_q    <= ~HSYNC_POL;
            vs_q    <= ~VSYNC_POL;
            de_q    <= 1'b0;
            pix_q   <= '0;
        end else begin
            s1_de_q <= s1_de_d;
            s1_hs_q <= s1_hs_d;
            s1_vs_q <= s1_vs_d;
            s1_cx_q <= s1_cx_d;
            s1_cy_q <= s1_cy_d;
            hs_q    <= s1_hs_q;
            vs_q    <= s1_vs_q;
            de_q    <= s1_de_q;
            pix_q   <= pix_d;
        end
    end

    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign de         = de_q;
    assign pixel      = pix_q;
    assign frame_tick = tick_q;
    assign head_x     = hx_q;
    assign head_y     = hy_q;
    assign lives      = lives_q;
    assign game_over  = go_q;

endmodule

// File: tb/tb_snake_frame_engine.sv
// tb/tb_snake_frame_engine.sv - randomized self-checking bench for snake_frame_engine
module tb_snake_frame_engine;

    localparam int HA = 24, HF = 2, HS = 3, HB = 2;
    localparam int VA = 16, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b1;
    localparam int C  = 1;
    localparam int ML = 8;
    localparam int IL = 3;
    localparam int MD = 2;
    localparam int LI = 2;
    localparam int LM = 3;
    localparam int GW = HA >> C;
    localparam int GH = VA >> C;
    localparam int XW = $clog2(GW);
    localparam int YW = $clog2(GH);
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    dir;
    logic          grow_evt, shrink_evt, life_evt;
    logic          hsync, vsync, de, frame_tick, game_over;
    logic [23:0]   pixel;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [2:0]    lives;

    always #5 clk = ~clk;

    snake_frame_engine #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .CELL_LOG2(C),
        .MAX_LEN(ML), .INIT_LEN(IL), .MOVE_DIV(MD),
        .LIVES_INIT(LI), .LIVES_MAX(LM)
    ) dut (
        .clk(clk), .reset_n(reset_n), .dir(dir),
        .grow_evt(grow_evt), .shrink_evt(shrink_evt), .life_evt(life_evt),
        .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel),
        .frame_tick(frame_tick), .head_x(head_x), .head_y(head_y),
        .lives(lives), .game_over(game_over)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n       = 0;

    // Reference model: snake as a list of cells, head first.
    int sx[$];
    int sy[$];
    int m_hd, m_lives, m_go, m_fc;
    bit pg, ps, pl;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    function automatic void respawn_snake();
        sx.delete();
        sy.delete();
        for (int i = 0; i < IL; i++) begin
            sx.push_back(GW / 2 - i);
            sy.push_back(GH / 2);
        end
        m_hd = 1;
        pg = 0; ps = 0; pl = 0;
    endfunction

    function automatic void model_reset();
        respawn_snake();
        m_lives = LI;
        m_go    = 0;
        m_fc    = 0;
    endfunction

    function automatic void model_step(input int d, input bit ge, input bit se, input bit le);
        int nx, ny, len, nl;
        bit died;
        if (d != (m_hd ^ 3)) m_hd = d;
        nx = sx[0];
        ny = sy[0];
        case (m_hd)
            1: nx = nx + 1;
            2: nx = nx - 1;
            3: ny = ny - 1;
            default: ny = ny + 1;
        endcase
        len  = sx.size();
        died = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
        for (int i = 1; i <= len - 2; i++) begin
            if (sx[i] == nx && sy[i] == ny) died = 1;
        end
        if (died) begin
            m_lives = m_lives - 1;
            if (m_lives == 0) m_go = 1;
            else respawn_snake();
        end else begin
            sx.push_front(nx);
            sy.push_front(ny);
            nl = len;
            if (pg && !ps) nl = (len + 1 > ML) ? ML : len + 1;
            else if (ps && !pg) nl = (len - 1 < 1) ? 1 : len - 1;
            while (sx.size() > nl) begin
                void'(sx.pop_back());
                void'(sy.pop_back());
            end
            if (pl && m_lives < LM) m_lives = m_lives + 1;
        end
        pg = ge; ps = se; pl = le;
    endfunction

    function automatic bit is_tick(input int nn);
        return (nn % HT == 0) && ((nn / HT) % VT == VA);
    endfunction

    // {hsync, vsync, de, pixel} expected after nn clock edges since release.
    function automatic logic [26:0] exp_video(input int nn);
        int t, h, v, cx, cy;
        logic hs, vs, dd;
        logic [23:0] px;
        if (nn < 2) return {~HPOL, ~VPOL, 1'b0, 24'h0};
        t  = nn - 2;
        h  = t % HT;
        v  = (t / HT) % VT;
        hs = (h >= HA + HF && h < HA + HF + HS) ? HPOL : ~HPOL;
        vs = (v >= VA + VF && v < VA + VF + VS) ? VPOL : ~VPOL;
        dd = (h < HA) && (v < VA);
        px = 24'h0;
        if (dd) begin
            cx = h >> C;
            cy = v >> C;
            px = m_go ? 24'h400000 : 24'h000000;
            for (int i = 0; i < sx.size(); i++) begin
                if (sx[i] == cx && sy[i] == cy) px = 24'h00FF00;
            end
            if (sx[0] == cx && sy[0] == cy) px = 24'hFFFF00;
        end
        return {hs, vs, dd, px};
    endfunction

    task automatic check_reset_state(input string tag);
        logic [26:0] rv;
        rv = {~HPOL, ~VPOL, 1'b0, 24'h0};
        check_eq({tag, "_video"}, {hsync, vsync, de, pixel}, rv);
        check_eq({tag, "_tick"}, frame_tick, 0);
        check_eq({tag, "_head"}, {head_x, head_y}, (GW / 2) * (1 << YW) + GH / 2);
        check_eq({tag, "_lives"}, lives, LI);
        check_eq({tag, "_game_over"}, game_over, 0);
    endtask

    // Asserted at a falling edge, i.e. anywhere in the frame; checked 1 ns later.
    task automatic apply_reset(input int hold);
        @(negedge clk);
        reset_n = 1'b0;
        grow_evt = 0; shrink_evt = 0; life_evt = 0;
        #1;
        check_reset_state("rst_assert");
        repeat (hold) @(negedge clk);
        check_reset_state("rst_hold");
        model_reset();
        n = 0;
        reset_n = 1'b1;
    endtask

    task automatic run_cycle(input int ep);
        bit ge, se, le;
        @(negedge clk);
        n++;
        check_eq("video", {hsync, vsync, de, pixel}, exp_video(n));
        check_eq("frame_tick", frame_tick, is_tick(n - 1));
        check_eq("head", {head_x, head_y}, sx[0] * (1 << YW) + sy[0]);
        check_eq("lives", lives, m_lives);
        check_eq("game_over", game_over, m_go);
        ge = 0; se = 0; le = 0;
        if (ep > 0) begin
            if ($urandom_range(0, 299) == 0) dir = 2'($urandom_range(0, 3));
            ge = ($urandom_range(0, (ep == 2) ? 799 : 2499) == 0);
            se = ($urandom_range(0, (ep == 2) ? 2999 : 4999) == 0);
            le = ($urandom_range(0, 2999) == 0);
        end
        grow_evt = ge; shrink_evt = se; life_evt = le;
        if (is_tick(n) && m_fc == MD - 1 && !m_go) begin
            model_step(int'(dir), ge, se, le);
        end else if (!m_go) begin
            pg = pg | ge; ps = ps | se; pl = pl | le;
        end
        if (is_tick(n)) m_fc = (m_fc + 1) % MD;
    endtask

    initial begin
        reset_n = 1'b1;
        dir = 2'b01;
        grow_evt = 0; shrink_evt = 0; life_evt = 0;
        model_reset();
        apply_reset(5);

        // Straight run right: two wall deaths, then game over and a frozen board.
        repeat (28 * FRAME) run_cycle(0);
        repeat ($urandom_range(1, FRAME)) run_cycle(0);
        apply_reset(3);

        dir = 2'b01;
        repeat (40 * FRAME) run_cycle(1);
        repeat ($urandom_range(1, FRAME)) run_cycle(1);
        apply_reset(2);

        dir = 2'b01;
        repeat (40 * FRAME) run_cycle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_frame_engine.md
# snake_frame_engine

Parametrised successor to the single-pixel display block. Combines a configurable video timing generator, a grid-based multi-segment snake (circular body buffer, grow/shrink, self- and wall-collision, lives) and a two-stage pipelined pixel renderer. It sits between the joystick/fruit/collision front end and the HDMI/TMDS encoder. All game state updates occur in vertical blanking, never during active video.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, active lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- HSYNC_POL / VSYNC_POL, 0 / 0, asserted sync level (0 = active-low)
- CELL_LOG2, 3, log2 of cell edge in pixels; GRID_W = H_ACTIVE>>CELL_LOG2, GRID_H = V_ACTIVE>>CELL_LOG2
- MAX_LEN, 16, body buffer depth in segments (power of 2)
- INIT_LEN, 3, length after reset or respawn (1..MAX_LEN)
- MOVE_DIV, 4, frames per snake step (>=1)
- LIVES_INIT / LIVES_MAX, 3 / 3, initial and saturating life count (<=7)

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- dir  in  2  heading request: 01 right, 10 left, 11 up, 00 down
- grow_evt / shrink_evt / life_evt  in  1 each  single-cycle event pulses
- hsync / vsync  out  1 each  sync, polarity per *_POL
- de  out  1  active-video enable
- pixel  out  24  RGB888
- frame_tick  out  1  one-cycle pulse at start of vertical blanking
- head_x  out  clog2(GRID_W)  current head cell column
- head_y  out  clog2(GRID_H)  current head cell row
- lives  out  3  remaining lives
- game_over  out  1  sticky; set when lives reach 0

## Operation
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) wrap; v increments when h wraps. Sync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and likewise for v.
- frame_tick is raised at h=0, v=V_ACTIVE. A frame counter (mod MOVE_DIV) advances on each tick. A step fires on the tick where the counter equals MOVE_DIV-1, provided game_over=0.
- Heading register:
  - Latched from dir at each step.
  - A request opposite to the current heading is ignored; the current heading is kept.
  - Reset/respawn heading is right.
- Body storage:
  - Circular buffer of MAX_LEN (x,y) cells, with head pointer and length len (1..MAX_LEN).
  - Segment i = buf[(hp - i) mod MAX_LEN], for i < len.
- Event latches: grow_evt, shrink_evt and life_evt each set a pending flag. Flags are cleared at every step, and on respawn.
- Step sequence:
  - new head = head ± 1 in the heading direction.
  - Death occurs if the new head is outside 0..GRID_W-1 / 0..GRID_H-1, or equals any segment i in 1..len-2. The tail is excluded because it vacates the cell.
  - On death:
    - lives decrements.
    - Pending events are discarded.
    - If lives becomes 0, game_over is set and all state freezes.
    - Otherwise the snake respawns: head at (GRID_W/2, GRID_H/2), segment i at (GRID_W/2 - i, GRID_H/2), len = INIT_LEN.
  - Otherwise:
    - hp increments (wraps) and the new head is written.
    - grow only: len+1, saturating at MAX_LEN.
    - shrink only: len-1, floor 1.
    - grow and shrink together: len unchanged.
    - life pending: lives+1, saturating at LIVES_MAX.
- Renderer:
  - Cell coordinates = h>>CELL_LOG2, v>>CELL_LOG2.
  - Colour priority: head 24'hFFFF00, then body segment 24'h00FF00, then background.
  - Background is 24'h000000 normally and 24'h400000 when game_over=1.
  - pixel = 0 whenever de=0.

## Timing
- Reset (async assert, sync release):
  - h = v = 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - de = 0, pixel = 0, frame_tick = 0.
  - lives = LIVES_INIT, game_over = 0, frame counter = 0.
  - Snake at its respawn state; all event flags clear.
- Output latency: hsync, vsync, de and pixel are registered with a fixed 2-cycle latency from the counters and are mutually aligned.
  - Stage 1: counter decode and cell coordinates.
  - Stage 2: segment compare and colour mux.
- frame_tick, head_x/y, lives and game_over are registered. They update in the cycle after the tick condition (h=0, v=V_ACTIVE).
- Events arriving in the same cycle as a step are latched for the next step, not the current one.
- Reset mid-frame returns everything to the reset state within one cycle of assertion.
- Recovery from game_over is by reset only.

## Test plan
- Reset values (defaults): hold reset_n low 5 cycles, then release.
  - hsync=1, vsync=1, de=0, pixel=0, lives=3, head=(40,30).
  - First de rises 2 cycles after release; hsync first falls 658 cycles after release.
  - Line period 800 cycles; frame period 420000 cycles.
- Movement (MOVE_DIV=1, dir=01 for 3 frames): head_x goes 41, 42, 43.
  - Then apply dir=10: ignored, head_x=44.
  - Pixel at cell (44,30) = FFFF00 and at (43,30) = 00FF00, both at 2-cycle latency.
- Length control:
  - Grow: pulse grow_evt 14 times, one per step; len saturates at 16.
  - Shrink: pulse grow_evt and shrink_evt in the same cycle; len unchanged.
  - Pulse shrink_evt 20 times; len floors at 1.
- Wall death and respawn: steer right until head_x=79, then step once more.
  - lives=2; head returns to (40,30) with len=3.
  - A life_evt pending in that frame is discarded.
- Self-collision and game over:
  - Grow to len=5, then turn up, left, down; lives decrements on the self-hit.
  - Repeat until lives=0: game_over=1 and background pixels read 400000.
  - Further dir/grow_evt inputs change nothing.
- Reset mid-operation: assert reset_n at h=300, v=200 with len=7 and lives=1.
  - Next cycle: all outputs at reset values, len=3, lives=3, game_over=0.
